risc_mem_arbiter: RTL and testbench

- Shares the 16-bit RISC core's single-port program/data memory between two requesters:
  - the Caravel management SoC, over the Wishbone slave port;
  - the core's own memory port.
- Holds the core halted after reset so firmware can load a program over Wishbone, then releases it through a control register.
- Sits inside the user project, between the Wishbone pins of the wrapper, the core, and the memory macro.

---
 rtl/risc_mem_arbiter_if.sv | 22 ++
 rtl/risc_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_risc_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_mem_arbiter_if.sv
// Wishbone classic slave bundle between the Caravel wrapper and the
// RISC memory arbiter. Signal names keep the wrapper's wbs_* spelling.
interface risc_mem_arbiter_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter: shares the RISC core's single-port 16-bit memory between
// the Caravel Wishbone slave port and the core's own memory port, and holds
// the core halted after reset until firmware clears CTRL.HALT.
// Build option: define RISC_MEM_ARB_CPU_PRIO_EN for fixed CPU priority;
// left undefined, ties in IDLE are resolved round-robin.
module risc_mem_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    risc_mem_arbiter_if.slave wbs,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [15:0]       cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [15:0]       cpu_rdata_o,
    output logic              cpu_halt_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    input  logic [15:0]       mem_rdata_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WB_WAIT = 2'd1;
    localparam logic [1:0] ST_WB_ACK  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        halt_q, halt_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        rvalid_q, rvalid_d;
    logic        ctrl_q, ctrl_d;
    logic        ctrl_wr_q, ctrl_wr_d;
    logic        ctrl_val_q, ctrl_val_d;

    logic wb_hit;
    logic wb_is_ctrl;
    logic cpu_ok;
    logic idle;
    logic wb_pick;
    logic cpu_pick;

    assign wb_hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                        (wbs.wbs_adr_i[31:24] == BASE_ADDR[31:24]);
    assign wb_is_ctrl = wbs.wbs_adr_i[ADDR_W+2];
    assign cpu_ok     = cpu_req_i & ~halt_q;
    // Gating with reset keeps the memory quiet while reset is held.
    assign idle       = (state_q == ST_IDLE) & wb_rst_n;

`ifdef RISC_MEM_ARB_CPU_PRIO_EN
    assign wb_pick = idle & wb_hit & ~cpu_ok;
`else
    logic last_wb_q, last_wb_d;

    assign wb_pick = idle & wb_hit & (~cpu_ok | ~last_wb_q);

    // Remember who was served last so a tie goes to the other requester.
    always_comb begin
        last_wb_d = last_wb_q;
        if (wb_pick) begin
            last_wb_d = 1'b1;
        end else if (cpu_pick) begin
            last_wb_d = 1'b0;
        end
    end

    // Round-robin flag register; resets to "CPU served last".
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            last_wb_q <= 1'b0;
        end else begin
            last_wb_q <= last_wb_d;
        end
    end
`endif

    assign cpu_pick = idle & cpu_ok & ~wb_pick;

    // Wishbone transfer sequencing and CTRL register next-state.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        dat_d      = dat_q;
        halt_d     = halt_q;
        ctrl_d     = ctrl_q;
        ctrl_wr_d  = ctrl_wr_q;
        ctrl_val_d = ctrl_val_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_pick) begin
                    state_d    = ST_WB_WAIT;
                    ctrl_d     = wb_is_ctrl;
                    ctrl_wr_d  = wb_is_ctrl & wbs.wbs_we_i & wbs.wbs_sel_i[0];
                    ctrl_val_d = wbs.wbs_dat_i[0];
                end
            end
            ST_WB_WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WB_ACK;
                    ack_d   = 1'b1;
                    dat_d   = ctrl_q ? {31'h0, halt_q} : {16'h0, mem_rdata_i};
                end
            end
            ST_WB_ACK: begin
                state_d = ST_IDLE;
                // HALT changes only once the ack is actually delivered.
                if (wbs.wbs_cyc_i && ctrl_wr_q) begin
                    halt_d = ctrl_val_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rvalid_d = cpu_pick & ~cpu_we_i;

    // State, CTRL and response registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= ST_IDLE;
            halt_q     <= 1'b1;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            rvalid_q   <= 1'b0;
            ctrl_q     <= 1'b0;
            ctrl_wr_q  <= 1'b0;
            ctrl_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            rvalid_q   <= rvalid_d;
            ctrl_q     <= ctrl_d;
            ctrl_wr_q  <= ctrl_wr_d;
            ctrl_val_q <= ctrl_val_d;
        end
    end

    // Memory port mux: the granted requester drives the macro directly.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (wb_pick) begin
            mem_en_o    = ~wb_is_ctrl;
            mem_we_o    = ~wb_is_ctrl & wbs.wbs_we_i & (&wbs.wbs_sel_i[1:0]);
            mem_addr_o  = wbs.wbs_adr_i[ADDR_W+1:2];
            mem_wdata_o = wbs.wbs_dat_i[15:0];
        end else if (cpu_pick) begin
            mem_en_o    = 1'b1;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end
    end

    // Dropping cyc during the ack cycle suppresses the ack.
    assign wbs.wbs_ack_o = ack_q & wbs.wbs_cyc_i;
    assign wbs.wbs_dat_o = dat_q;
    assign cpu_gnt_o     = cpu_pick;
    assign cpu_rvalid_o  = rvalid_q;
    assign cpu_rdata_o   = rvalid_q ? mem_rdata_i : '0;
    assign cpu_halt_o    = halt_q;

    logic unused_wb_bits;
    assign unused_wb_bits = ^{wbs.wbs_sel_i[3:2], wbs.wbs_dat_i[31:16],
                              wbs.wbs_adr_i[23:ADDR_W+3], wbs.wbs_adr_i[1:0]};

endmodule

// File: tb/tb_risc_mem_arbiter.sv
`timescale 1ns/1ps
module tb_risc_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    risc_mem_arbiter_if wb_if();

    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_halt;
    logic [15:0] cpu_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    risc_mem_arbiter #(.ADDR_W(8), .BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .wbs         (wb_if),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_gnt_o   (cpu_gnt),
        .cpu_rvalid_o(cpu_rvalid),
        .cpu_rdata_o (cpu_rdata),
        .cpu_halt_o  (cpu_halt),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Memory macro: synchronous single port, read data one cycle after enable.
    logic [15:0] mem [256] = '{default: 16'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Reference model state.
    logic [15:0] ref_mem [256] = '{default: 16'h0};
    bit ref_halt = 1'b1;
    bit ref_last_wb = 1'b0;

    int n_pass = 0, n_total = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_n);
    endfunction

    typedef struct {
        int          cyc;
        logic [31:0] val;
        bit          chk;
    } exp_t;
    exp_t wb_sb[$];
    exp_t cpu_sb[$];
    exp_t wb_e, cpu_e;

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rst_n && wb_if.wbs_ack_o) begin
            if (wb_sb.size() == 0) check("wb_unexpected_ack", 32'd1, 32'd0);
            else begin
                wb_e = wb_sb.pop_front();
                check("wb_ack_cycle", cyc_n, wb_e.cyc);
                if (wb_e.chk) check("wb_rdata", wb_if.wbs_dat_o, wb_e.val);
            end
        end
        if (rst_n && cpu_rvalid) begin
            if (cpu_sb.size() == 0) check("cpu_unexpected_rvalid", 32'd1, 32'd0);
            else begin
                cpu_e = cpu_sb.pop_front();
                check("cpu_rvalid_cycle", cyc_n, cpu_e.cyc);
                check("cpu_rdata", {16'h0, cpu_rdata}, cpu_e.val);
            end
        end
    end

    // One WB and/or CPU request issued in the same cycle; abort_at>0 drops
    // cyc that many cycles after the WB access is picked.
    task automatic xfer(input bit do_wb, input logic [31:0] adr, input logic [31:0] dat,
                        input bit we, input logic [3:0] sel, input int abort_at,
                        input bit do_cpu, input logic [7:0] caddr, input bit cwe,
                        input logic [15:0] cwd);
        bit hit, is_ctrl, wb_live, cpu_live, picked, ack_seen, en_seen, tie, blocked;
        bit drop_wb, drop_cpu, exp_en, exp_we, exp_cpu, halt_wr;
        logic [7:0] word;
        int p;
        hit = (adr[31:24] == 8'h30);
        is_ctrl = adr[10];
        word = adr[9:2];
        @(posedge clk); #1;
        if (do_wb) begin
            wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_stb_i = 1'b1; wb_if.wbs_we_i = we;
            wb_if.wbs_sel_i = sel; wb_if.wbs_adr_i = adr; wb_if.wbs_dat_i = dat;
        end
        if (do_cpu) begin
            cpu_req = 1'b1; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        end
        wb_live = do_wb; cpu_live = do_cpu; picked = 0; ack_seen = 0; en_seen = 0;
        halt_wr = 0; p = -100;
        tie = do_wb && hit && do_cpu;
        blocked = do_cpu && ref_halt;
        for (int k = 0; k < 40 && (wb_live || cpu_live); k++) begin
            @(negedge clk);
            drop_wb = 0; drop_cpu = 0;
            if (tie && k == 0) begin
`ifdef RISC_MEM_ARB_CPU_PRIO_EN
                exp_cpu = !ref_halt;
`else
                exp_cpu = !ref_halt && ref_last_wb;
`endif
                check("tie_winner_cpu", cpu_gnt, exp_cpu);
            end
            if (cpu_live && blocked) begin
                if (cpu_gnt || k == 5) begin
                    check("halt_blocks_gnt", cpu_gnt, 1'b0);
                    cpu_live = 0; drop_cpu = 1;
                end
            end else if (cpu_live && cpu_gnt) begin
                check("cpu_mem_strobe", {mem_en, mem_we, mem_addr, cwe ? mem_wdata : 16'h0},
                      {1'b1, cwe, caddr, cwe ? cwd : 16'h0});
                if (picked) check("cpu_gnt_after_wb", k, p + ((abort_at == 1) ? 2 : 3));
                else check("cpu_gnt_cycle", k, 0);
                ref_last_wb = 1'b0;
                if (cwe) ref_mem[caddr] = cwd;
                else cpu_sb.push_back('{cyc_n + 1, {16'h0, ref_mem[caddr]}, 1'b1});
                cpu_live = 0; drop_cpu = 1;
            end
            if (wb_live && hit && !picked && !cpu_gnt) begin
                picked = 1; p = k; ref_last_wb = 1'b1;
                exp_en = !is_ctrl;
                exp_we = !is_ctrl && we && (sel[1:0] == 2'b11);
                check("wb_mem_strobe",
                      {mem_en, mem_we, exp_en ? mem_addr : 8'h0, exp_we ? mem_wdata : 16'h0},
                      {exp_en, exp_we, exp_en ? word : 8'h0, exp_we ? dat[15:0] : 16'h0});
                if (exp_we) ref_mem[word] = dat[15:0];
                halt_wr = is_ctrl && we && sel[0];
                if (abort_at <= 0)
                    wb_sb.push_back('{cyc_n + 2,
                                      is_ctrl ? {31'h0, ref_halt} : {16'h0, ref_mem[word]},
                                      !we});
            end
            if (wb_if.wbs_ack_o) ack_seen = 1;
            if (wb_live && hit && picked) begin
                if (abort_at > 0) begin
                    if (k == p + abort_at - 1) drop_wb = 1;
                    if (k == p + 4) begin
                        check("abort_no_ack", ack_seen, 1'b0);
                        wb_live = 0;
                    end
                end else if (wb_if.wbs_ack_o) begin
                    check("wb_ack_latency", k, p + 2);
                    if (halt_wr) ref_halt = dat[0];
                    wb_live = 0; drop_wb = 1;
                end
            end
            if (wb_live && !hit) begin
                en_seen |= mem_en;
                if (k == 5) begin
                    check("nohit_ack", ack_seen, 1'b0);
                    if (!do_cpu) check("nohit_mem_en", en_seen, 1'b0);
                    wb_live = 0; drop_wb = 1;
                end
            end
            @(posedge clk); #1;
            if (drop_cpu) cpu_req = 1'b0;
            if (drop_wb) begin wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; end
        end
        if (wb_live || cpu_live) check("xfer_timeout", 32'd1, 32'd0);
        wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_halt", cpu_halt, ref_halt);
    endtask

    task automatic wb_only(input logic [31:0] adr, input logic [31:0] dat, input bit we,
                           input logic [3:0] sel, input int abort_at);
        xfer(1'b1, adr, dat, we, sel, abort_at, 1'b0, 8'h0, 1'b0, 16'h0);
    endtask

    task automatic cpu_only(input logic [7:0] a, input bit we, input logic [15:0] d);
        xfer(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 1'b1, a, we, d);
    endtask

    localparam logic [31:0] CTRL = 32'h3000_0400;
    logic [3:0] sels [4] = '{4'hF, 4'h3, 4'h1, 4'hC};

    initial begin
        bit seen;
        int mode;
        logic [31:0] radr;
        wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; wb_if.wbs_we_i = 1'b0;
        wb_if.wbs_sel_i = '0; wb_if.wbs_adr_i = '0; wb_if.wbs_dat_i = '0;
        cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", wb_if.wbs_ack_o, 1'b0);
        check("rst_dat", wb_if.wbs_dat_o, 32'h0);
        check("rst_cpu", {cpu_gnt, cpu_rvalid, cpu_rdata}, 18'h0);
        check("rst_mem", {mem_en, mem_we}, 2'b00);
        check("rst_halt", cpu_halt, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1; cpu_req = 1'b0;

        cpu_only(8'd0, 1'b0, 16'h0);
        wb_only(32'h3000_0010, 32'h0000_BEEF, 1'b1, 4'hF, 0);
        wb_only(32'h3000_0010, 32'h0, 1'b0, 4'hF, 0);
        wb_only(CTRL, 32'h0, 1'b0, 4'hF, 0);
        wb_only(CTRL, 32'h0, 1'b1, 4'hF, 0);
        cpu_only(8'd4, 1'b0, 16'h0);
        // Two ties back to back.
        xfer(1'b1, 32'h3000_0050, 32'h0000_1357, 1'b1, 4'hF, 0, 1'b1, 8'd4, 1'b0, 16'h0);
        xfer(1'b1, 32'h3000_0054, 32'h0000_2468, 1'b1, 4'hF, 0, 1'b1, 8'd20, 1'b0, 16'h0);
        // Partial byte select must not write.
        wb_only(32'h3000_0010, 32'h0000_1111, 1'b1, 4'h1, 0);
        wb_only(32'h3000_0010, 32'h0, 1'b0, 4'hF, 0);
        // Address outside the base window.
        wb_only(32'h2000_0000, 32'h0000_DEAD, 1'b1, 4'hF, 0);
        // Abort in WB_WAIT with a pending CPU read of the just-written word.
        cpu_only(8'd31, 1'b1, 16'h4242);
        xfer(1'b1, 32'h3000_0078, 32'h0000_7777, 1'b1, 4'hF, 1, 1'b1, 8'd30, 1'b0, 16'h0);
        wb_only(32'h3000_0078, 32'h0, 1'b0, 4'hF, 0);
        // Abort in WB_ACK.
        wb_only(32'h3000_007C, 32'h0, 1'b0, 4'hF, 2);
        // HALT=1 write racing an earlier-granted CPU read.
        xfer(1'b1, CTRL, 32'h1, 1'b1, 4'h1, 0, 1'b1, 8'd31, 1'b0, 16'h0);
        cpu_only(8'd31, 1'b0, 16'h0);
        wb_only(CTRL, 32'h0, 1'b1, 4'h1, 0);

        // Reset in the middle of a WB write.
        @(posedge clk); #1;
        wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_stb_i = 1'b1; wb_if.wbs_we_i = 1'b1;
        wb_if.wbs_sel_i = 4'hF; wb_if.wbs_adr_i = 32'h3000_0024; wb_if.wbs_dat_i = 32'h1234;
        @(negedge clk);
        check("rst_mid_pick", mem_en, 1'b1);
        ref_mem[9] = 16'h1234;
        @(posedge clk); #1;
        rst_n = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen |= wb_if.wbs_ack_o | mem_en;
        end
        check("rst_mid_quiet", seen, 1'b0);
        check("rst_mid_halt", cpu_halt, 1'b1);
        @(posedge clk); #1;
        wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; rst_n = 1'b1;
        ref_halt = 1'b1; ref_last_wb = 1'b0;
        wb_only(32'h3000_0024, 32'h0, 1'b0, 4'hF, 0);
        wb_only(CTRL, 32'h0, 1'b1, 4'hF, 0);

        // Randomized mix of WB, CPU and simultaneous requests.
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 2));
            radr = 32'h3000_0000 | ({28'h0, 4'($urandom)} << 2);
            if ($urandom_range(0, 7) == 0) radr = CTRL;
            xfer(mode != 1, radr, $urandom, (radr != CTRL) && $urandom_range(0, 1) == 1,
                 sels[$urandom_range(0, 3)], 0,
                 mode != 0, 8'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, 16'($urandom));
        end

        repeat (3) @(negedge clk);
        check("wb_sb_drained", wb_sb.size(), 0);
        check("cpu_sb_drained", cpu_sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
